// File: rtl/mem_responder.sv
// Fixed-latency word memory behind a request/ready handshake.
// One access at a time: IDLE accepts, WAIT counts down, DONE pulses mem_ready.
module mem_responder #(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     din_q;
  logic            read_q;
  logic            write_q;
  logic            err_q;
  logic            accept;
  logic            finish;
  logic            req_err;
  logic            mem_we;
  logic [31:0]     mem [DEPTH_WORDS];

  // Errors are judged on the request as seen at the acceptance edge only.
  assign req_err = (addr[1:0] != 2'b00) || ({1'b0, addr} >= LIMIT)
                || (mem_read && mem_write);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      dout    <= 32'd0;
      idx_q   <= '0;
      din_q   <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx_q   <= addr[AW+1:2];
        din_q   <= din;
        read_q  <= mem_read;
        write_q <= mem_write;
        err_q   <= req_err;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        if (err_q)
          dout <= 32'd0;
        else if (read_q)
          dout <= mem[idx_q];
      end
    end
  end

  assign mem_we = finish && write_q && !err_q;

  // NOTE: the storage array is deliberately not reset; contents survive reset,
  // and only the write strobe is gated by it so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[idx_q] <= din_q;
  end

  assign mem_ready = (state == DONE);
  assign err       = (state == DONE) && err_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, cycles from request acceptance to mem_ready (legal 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_read  input  1  read request level from control unit.
REQ-006 SHALL have port mem_write  input  1  write request level from control unit.
REQ-007 SHALL have port addr  input  32  byte address (IorD-selected PC or ALUOut).
REQ-008 SHALL have port din  input  32  write data.
REQ-009 SHALL have port dout  output  32  registered read data.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port err  output  1  error flag, valid only while mem_ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE; only IDLE samples requests.
REQ-014 IDLE, edge with mem_read|mem_write=1: latch addr, din, op; cnt<=LATENCY-1; go WAIT (acceptance edge T0).
REQ-015 WAIT: cnt!=0 -> cnt-1, stay; cnt==0 -> go DONE; inputs ignored throughout WAIT.
REQ-016 DONE: mem_ready=1, err valid; next edge unconditionally -> IDLE.
REQ-017 mem_ready SHALL rise at edge T0+LATENCY and fall at T0+LATENCY+1; earliest next acceptance edge T0+LATENCY+2.
REQ-018 Requester SHALL deassert request at edge T0+LATENCY+1; a request still high in IDLE is a new request.
REQ-019 Word index = latched addr[log2(DEPTH_WORDS)+1:2].
REQ-020 Error when addr[1:0]!=0, addr >= 4*DEPTH_WORDS, or mem_read and mem_write both high at acceptance.
REQ-021 Valid write: memory word updated on WAIT->DONE edge; dout unchanged.
REQ-022 Valid read: dout<=word on WAIT->DONE edge; reflects any prior completed write (no stale data).
REQ-023 Error: no memory update, dout<=0, err=1 during DONE.
REQ-024 err, mem_ready SHALL be 0 outside DONE; busy = (state!=IDLE).
REQ-025 cnt width 4 bits; no wrap beyond LATENCY-1.

Reset
REQ-026 reset dominates all other inputs at the edge where it is sampled.
REQ-027 After reset: state=IDLE, cnt=0, dout=0, mem_ready=0, busy=0, err=0.
REQ-028 Reset in WAIT SHALL abort the access; pending write not performed, no mem_ready pulse.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 Request high during the reset edge SHALL NOT be accepted; first acceptance on first non-reset edge in IDLE.

Verification
REQ-031 LATENCY=3: write addr=0x10 din=0xDEADBEEF at T0 -> mem_ready pulse T0+3..T0+4, err=0; then read 0x10 -> dout=0xDEADBEEF at ready.
REQ-032 LATENCY=1: read 0x0 accepted T0 -> busy high T0..T0+2, mem_ready high only T0+1..T0+2.
REQ-033 Read addr=0x6 (misaligned) and addr=0x400 (DEPTH 256) -> err=1 with mem_ready, dout=0, memory unchanged.
REQ-034 mem_read=mem_write=1 at acceptance, addr=0x20 din=0x1 -> err=1, later read of 0x20 returns prior value.
REQ-035 Write 0x55 to 0x8 then reset asserted at T0+1 of second write 0xAA to 0x8 -> no ready pulse, state IDLE; read 0x8 -> 0x55.
REQ-036 Change addr/din each cycle during WAIT -> operation uses values latched at T0.
